// File: rtl/cpu_datapath.sv
// Single-bus 32-bit CPU datapath: register file, special registers, ALU, encoder and word RAM.
// Every register exports its contents so the control unit and bench can observe it.
module cpu_datapath #(
    parameter string MEM_INIT_FILE = "memory.hex"
) (
    input  logic        Clock,
    input  logic        Clear,
    input  logic        HIin,
    input  logic        LOin,
    input  logic        PCin,
    input  logic        MDRin,
    input  logic        Zin,
    input  logic        Yin,
    input  logic        MARin,
    input  logic        IRin,
    input  logic        CONin,
    input  logic        OUTPORTin,
    input  logic        HIout,
    input  logic        LOout,
    input  logic        ZHIout,
    input  logic        ZLOout,
    input  logic        PCout,
    input  logic        MDRout,
    input  logic        INPORTout,
    input  logic        OUTPORTout,
    input  logic        Cout,
    input  logic        Yout,
    input  logic        Gra,
    input  logic        Grb,
    input  logic        Grc,
    input  logic        Rin,
    input  logic        Rout,
    input  logic        BAout,
    input  logic        Read,
    input  logic        IncPC,
    input  logic        write,
    input  logic [31:0] inportInput,
    input  logic [15:0] regIn,
    output logic [31:0] busMuxOut,
    output logic [4:0]  encoderOut,
    output logic        CON,
    output logic [31:0] BusMuxInR0,
    output logic [31:0] BusMuxInR1,
    output logic [31:0] BusMuxInR2,
    output logic [31:0] BusMuxInR3,
    output logic [31:0] BusMuxInR4,
    output logic [31:0] BusMuxInR5,
    output logic [31:0] BusMuxInR6,
    output logic [31:0] BusMuxInR7,
    output logic [31:0] BusMuxInR8,
    output logic [31:0] BusMuxInR9,
    output logic [31:0] BusMuxInR10,
    output logic [31:0] BusMuxInR11,
    output logic [31:0] BusMuxInR12,
    output logic [31:0] BusMuxInR13,
    output logic [31:0] BusMuxInR14,
    output logic [31:0] BusMuxInR15,
    output logic [31:0] BusMuxInHI,
    output logic [31:0] BusMuxInLO,
    output logic [31:0] BusMuxInZhi,
    output logic [31:0] BusMuxInZlo,
    output logic [31:0] BusMuxInPC,
    output logic [31:0] BusMuxInMDR,
    output logic [31:0] BusMuxInInport,
    output logic [31:0] BusMuxInOutport,
    output logic [31:0] BusMuxInY,
    output logic [31:0] IRregister,
    output logic [31:0] Cregister,
    output logic [8:0]  marToRam
);

    logic [31:0] gpr_reg [16];
    logic [31:0] hi_reg, lo_reg, pc_reg, ir_reg, mdr_reg, y_reg;
    logic [31:0] inport_reg, outport_reg;
    logic [63:0] z_reg;
    logic [8:0]  mar_reg;
    logic        con_reg;

    logic [31:0] ram [512];

    logic [31:0] bus;
    logic [4:0]  enc;
    logic [25:0] bus_req;
    logic [3:0]  sel_idx;
    logic [15:0] sel_dec, gpr_load, gpr_drive;
    logic [31:0] c_sext;
    logic [63:0] alu_result;
    logic        con_next;

    assign sel_idx = (ir_reg[26:23] & {4{Gra}})
                   | (ir_reg[22:19] & {4{Grb}})
                   | (ir_reg[18:15] & {4{Grc}});

    for (genvar gi = 0; gi < 16; gi++) begin : g_sel
        assign sel_dec[gi]   = (sel_idx == 4'(gi));
        assign gpr_load[gi]  = (sel_dec[gi] & Rin) | regIn[gi];
        assign gpr_drive[gi] = sel_dec[gi] & (Rout | BAout);
    end

    assign c_sext = {{13{ir_reg[18]}}, ir_reg[18:0]};

    assign bus_req = {Yout, OUTPORTout, Cout, INPORTout, MDRout, PCout,
                      ZLOout, ZHIout, LOout, HIout, gpr_drive};

    // Lowest requesting code wins; 31 means the bus is idle.
    always_comb begin
        enc = 5'd31;
        for (int i = 25; i >= 0; i--) begin
            if (bus_req[i]) enc = i[4:0];
        end
    end

    always_comb begin
        bus = '0;
        if (enc < 5'd16) begin
            bus = (BAout && enc == 5'd0) ? 32'd0 : gpr_reg[enc[3:0]];
        end else begin
            case (enc)
                5'd16:   bus = hi_reg;
                5'd17:   bus = lo_reg;
                5'd18:   bus = z_reg[63:32];
                5'd19:   bus = z_reg[31:0];
                5'd20:   bus = pc_reg;
                5'd21:   bus = mdr_reg;
                5'd22:   bus = inport_reg;
                5'd23:   bus = c_sext;
                5'd24:   bus = outport_reg;
                5'd25:   bus = y_reg;
                default: bus = '0;
            endcase
        end
    end

    logic [31:0]        alu_a, alu_b;
    logic signed [31:0] alu_a_s, alu_b_s;
    logic [4:0]         shamt;
    logic [63:0]        rot_right, rot_left;
    logic signed [63:0] prod;

    assign alu_a     = y_reg;
    assign alu_b     = bus;
    assign alu_a_s   = y_reg;
    assign alu_b_s   = bus;
    assign shamt     = bus[4:0];
    assign rot_right = {alu_a, alu_a} >> shamt;
    assign rot_left  = {alu_a, alu_a} << shamt;
    assign prod      = $signed({{32{alu_a[31]}}, alu_a}) * $signed({{32{alu_b[31]}}, alu_b});

    always_comb begin
        alu_result = '0;
        case (ir_reg[31:27])
            5'b00100: alu_result = {32'd0, alu_a - alu_b};
            5'b00101: alu_result = {32'd0, alu_a & alu_b};
            5'b00110: alu_result = {32'd0, alu_a | alu_b};
            5'b00111: alu_result = {32'd0, rot_right[31:0]};
            5'b01000: alu_result = {32'd0, rot_left[63:32]};
            5'b01001: alu_result = {32'd0, alu_a >> shamt};
            5'b01010: alu_result = {32'd0, 32'(alu_a_s >>> shamt)};
            5'b01011: alu_result = {32'd0, alu_a << shamt};
            5'b01101: alu_result = {32'd0, alu_a & alu_b};
            5'b01110: alu_result = {32'd0, alu_a | alu_b};
            // Divide by zero yields Z=0 rather than an undefined value.
            5'b01111: if (alu_b != 32'd0)
                          alu_result = {32'(alu_a_s % alu_b_s), 32'(alu_a_s / alu_b_s)};
            5'b10000: alu_result = prod;
            5'b10001: alu_result = {32'd0, 32'd0 - alu_b};
            5'b10010: alu_result = {32'd0, ~alu_b};
            default:  alu_result = {32'd0, alu_a + alu_b};
        endcase
    end

    always_comb begin
        con_next = 1'b0;
        case (ir_reg[20:19])
            2'b00: con_next = (bus == 32'd0);
            2'b01: con_next = (bus != 32'd0);
            2'b10: con_next = !bus[31] && (bus != 32'd0);
            2'b11: con_next = bus[31];
            default: con_next = 1'b0;
        endcase
    end

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            for (int i = 0; i < 16; i++) gpr_reg[i] <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            pc_reg      <= '0;
            ir_reg      <= '0;
            mar_reg     <= '0;
            mdr_reg     <= '0;
            y_reg       <= '0;
            z_reg       <= '0;
            inport_reg  <= '0;
            outport_reg <= '0;
            con_reg     <= 1'b0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (gpr_load[i]) gpr_reg[i] <= bus;
            end
            if (HIin)      hi_reg      <= bus;
            if (LOin)      lo_reg      <= bus;
            if (PCin)      pc_reg      <= IncPC ? pc_reg + 32'd1 : bus;
            if (IRin)      ir_reg      <= bus;
            if (MARin)     mar_reg     <= bus[8:0];
            if (MDRin)     mdr_reg     <= Read ? ram[mar_reg] : bus;
            if (Yin)       y_reg       <= bus;
            if (Zin)       z_reg       <= alu_result;
            if (OUTPORTin) outport_reg <= bus;
            if (CONin)     con_reg     <= con_next;
            inport_reg <= inportInput;
        end
    end

    // RAM contents survive Clear.
    always_ff @(posedge Clock) begin
        if (write) ram[mar_reg] <= mdr_reg;
    end

    assign busMuxOut       = bus;
    assign encoderOut      = enc;
    assign CON             = con_reg;
    assign BusMuxInR0      = gpr_reg[0];
    assign BusMuxInR1      = gpr_reg[1];
    assign BusMuxInR2      = gpr_reg[2];
    assign BusMuxInR3      = gpr_reg[3];
    assign BusMuxInR4      = gpr_reg[4];
    assign BusMuxInR5      = gpr_reg[5];
    assign BusMuxInR6      = gpr_reg[6];
    assign BusMuxInR7      = gpr_reg[7];
    assign BusMuxInR8      = gpr_reg[8];
    assign BusMuxInR9      = gpr_reg[9];
    assign BusMuxInR10     = gpr_reg[10];
    assign BusMuxInR11     = gpr_reg[11];
    assign BusMuxInR12     = gpr_reg[12];
    assign BusMuxInR13     = gpr_reg[13];
    assign BusMuxInR14     = gpr_reg[14];
    assign BusMuxInR15     = gpr_reg[15];
    assign BusMuxInHI      = hi_reg;
    assign BusMuxInLO      = lo_reg;
    assign BusMuxInZhi     = z_reg[63:32];
    assign BusMuxInZlo     = z_reg[31:0];
    assign BusMuxInPC      = pc_reg;
    assign BusMuxInMDR     = mdr_reg;
    assign BusMuxInInport  = inport_reg;
    assign BusMuxInOutport = outport_reg;
    assign BusMuxInY       = y_reg;
    assign IRregister      = ir_reg;
    assign Cregister       = c_sext;
    assign marToRam        = mar_reg;

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed bench for cpu_datapath: fetch, mflo, ALU ops, BAout, CON and mid-cycle Clear.
module tb_cpu_datapath;

    logic        Clock = 1'b0;
    logic        Clear;
    logic        HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin, OUTPORTin;
    logic        HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, OUTPORTout, Cout, Yout;
    logic        Gra, Grb, Grc, Rin, Rout, BAout, Read, IncPC, write;
    logic [31:0] inportInput;
    logic [15:0] regIn;
    logic [31:0] busMuxOut;
    logic [4:0]  encoderOut;
    logic        CON;
    logic [31:0] r_obs [16];
    logic [31:0] hi_obs, lo_obs, zhi_obs, zlo_obs, pc_obs, mdr_obs, inport_obs, outport_obs, y_obs;
    logic [31:0] ir_obs, c_obs;
    logic [8:0]  mar_obs;

    int check_count = 0;
    int pass_count  = 0;

    always #5 Clock = ~Clock;

    cpu_datapath #(.MEM_INIT_FILE("")) dut (
        .Clock(Clock), .Clear(Clear),
        .HIin(HIin), .LOin(LOin), .PCin(PCin), .MDRin(MDRin), .Zin(Zin), .Yin(Yin),
        .MARin(MARin), .IRin(IRin), .CONin(CONin), .OUTPORTin(OUTPORTin),
        .HIout(HIout), .LOout(LOout), .ZHIout(ZHIout), .ZLOout(ZLOout), .PCout(PCout),
        .MDRout(MDRout), .INPORTout(INPORTout), .OUTPORTout(OUTPORTout), .Cout(Cout), .Yout(Yout),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .Read(Read), .IncPC(IncPC), .write(write),
        .inportInput(inportInput), .regIn(regIn),
        .busMuxOut(busMuxOut), .encoderOut(encoderOut), .CON(CON),
        .BusMuxInR0(r_obs[0]), .BusMuxInR1(r_obs[1]), .BusMuxInR2(r_obs[2]), .BusMuxInR3(r_obs[3]),
        .BusMuxInR4(r_obs[4]), .BusMuxInR5(r_obs[5]), .BusMuxInR6(r_obs[6]), .BusMuxInR7(r_obs[7]),
        .BusMuxInR8(r_obs[8]), .BusMuxInR9(r_obs[9]), .BusMuxInR10(r_obs[10]), .BusMuxInR11(r_obs[11]),
        .BusMuxInR12(r_obs[12]), .BusMuxInR13(r_obs[13]), .BusMuxInR14(r_obs[14]), .BusMuxInR15(r_obs[15]),
        .BusMuxInHI(hi_obs), .BusMuxInLO(lo_obs), .BusMuxInZhi(zhi_obs), .BusMuxInZlo(zlo_obs),
        .BusMuxInPC(pc_obs), .BusMuxInMDR(mdr_obs), .BusMuxInInport(inport_obs),
        .BusMuxInOutport(outport_obs), .BusMuxInY(y_obs),
        .IRregister(ir_obs), .Cregister(c_obs), .marToRam(mar_obs)
    );

    task automatic clear_ctl();
        HIin = 0; LOin = 0; PCin = 0; MDRin = 0; Zin = 0; Yin = 0; MARin = 0; IRin = 0;
        CONin = 0; OUTPORTin = 0; HIout = 0; LOout = 0; ZHIout = 0; ZLOout = 0; PCout = 0;
        MDRout = 0; INPORTout = 0; OUTPORTout = 0; Cout = 0; Yout = 0; Gra = 0; Grb = 0;
        Grc = 0; Rin = 0; Rout = 0; BAout = 0; Read = 0; IncPC = 0; write = 0; regIn = '0;
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Put a value on the inport and give it one edge to be sampled.
    task automatic set_inport(input logic [31:0] v);
        clear_ctl();
        inportInput = v;
        tick();
    endtask

    task automatic test_reset();
        clear_ctl();
        inportInput = 32'h0;
        Clear = 1'b1;
        tick();
        tick();
        check_count++; if (pc_obs !== 32'd0) $display("FAIL reset_pc: got %h want 0", pc_obs); else pass_count++;
        check_count++; if (ir_obs !== 32'd0) $display("FAIL reset_ir: got %h want 0", ir_obs); else pass_count++;
        check_count++; if ({zhi_obs, zlo_obs} !== 64'd0) $display("FAIL reset_z: got %h want 0", {zhi_obs, zlo_obs}); else pass_count++;
        check_count++; if (CON !== 1'b0) $display("FAIL reset_con: got %b want 0", CON); else pass_count++;
        check_count++; if (encoderOut !== 5'd31) $display("FAIL reset_enc_idle: got %0d want 31", encoderOut); else pass_count++;
        check_count++; if (busMuxOut !== 32'd0) $display("FAIL reset_bus_idle: got %h want 0", busMuxOut); else pass_count++;
        Clear = 1'b0;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_inport_to_pc();
        set_inport(32'd16);
        INPORTout = 1; PCin = 1; Zin = 1;
        #1;
        check_count++; if (encoderOut !== 5'd22) $display("FAIL inport_enc: got %0d want 22", encoderOut); else pass_count++;
        check_count++; if (busMuxOut !== 32'd16) $display("FAIL inport_bus: got %0d want 16", busMuxOut); else pass_count++;
        tick();
        clear_ctl();
        check_count++; if (pc_obs !== 32'd16) $display("FAIL inport_pc: got %0d want 16", pc_obs); else pass_count++;
        check_count++; if (zlo_obs !== 32'd16) $display("FAIL inport_zlo_add: got %0d want 16", zlo_obs); else pass_count++;
        $display("test_inport_to_pc done");
    endtask

    task automatic test_lo_load();
        set_inport(32'd53);
        INPORTout = 1; LOin = 1; OUTPORTin = 1;
        tick();
        clear_ctl();
        check_count++; if (lo_obs !== 32'd53) $display("FAIL lo_load: got %0d want 53", lo_obs); else pass_count++;
        check_count++; if (outport_obs !== 32'd53) $display("FAIL outport_load: got %0d want 53", outport_obs); else pass_count++;
        $display("test_lo_load done");
    endtask

    task automatic test_fetch();
        // Store 0xCB000000 into RAM[16] through MDR/MAR.
        set_inport(32'hCB000000);
        INPORTout = 1; MDRin = 1; tick();
        clear_ctl(); PCout = 1; MARin = 1; tick();
        clear_ctl(); write = 1; tick();
        clear_ctl(); MDRout = 1; MARin = 1; tick();
        clear_ctl(); PCout = 1; MARin = 1; tick();
        clear_ctl();
        check_count++; if (mar_obs !== 9'd16) $display("FAIL fetch_t0_mar: got %0d want 16", mar_obs); else pass_count++;
        Read = 1; MDRin = 1; PCin = 1; IncPC = 1; tick();
        clear_ctl();
        check_count++; if (pc_obs !== 32'd17) $display("FAIL fetch_t1_pc: got %0d want 17", pc_obs); else pass_count++;
        check_count++; if (mdr_obs !== 32'hCB000000) $display("FAIL fetch_t1_mdr: got %h want cb000000", mdr_obs); else pass_count++;
        MDRout = 1; IRin = 1; tick();
        clear_ctl();
        check_count++; if (ir_obs !== 32'hCB000000) $display("FAIL fetch_t2_ir: got %h want cb000000", ir_obs); else pass_count++;
        check_count++; if (c_obs !== 32'd0) $display("FAIL fetch_creg: got %h want 0", c_obs); else pass_count++;
        Gra = 1; Rin = 1; LOout = 1; tick();
        clear_ctl();
        check_count++; if (r_obs[6] !== 32'd53) $display("FAIL mflo_r6: got %0d want 53", r_obs[6]); else pass_count++;
        for (int i = 0; i < 16; i++) begin
            if (i != 6) begin
                check_count++;
                if (r_obs[i] !== 32'd0) $display("FAIL mflo_other_r%0d: got %h want 0", i, r_obs[i]); else pass_count++;
            end
        end
        $display("test_fetch done");
    endtask

    task automatic test_mul();
        set_inport(32'd5);  INPORTout = 1; regIn[3] = 1; tick();
        set_inport(32'd7);  INPORTout = 1; regIn[4] = 1; tick();
        // mul with Ra=3, Rb=4
        set_inport(32'h81A00000); INPORTout = 1; IRin = 1; tick();
        clear_ctl(); Gra = 1; Rout = 1; Yin = 1; tick();
        clear_ctl();
        check_count++; if (y_obs !== 32'd5) $display("FAIL mul_y: got %0d want 5", y_obs); else pass_count++;
        Grb = 1; Rout = 1; Zin = 1;
        #1;
        check_count++; if (encoderOut !== 5'd4) $display("FAIL mul_enc_r4: got %0d want 4", encoderOut); else pass_count++;
        tick();
        clear_ctl();
        check_count++; if (zlo_obs !== 32'd35) $display("FAIL mul_zlo: got %0d want 35", zlo_obs); else pass_count++;
        check_count++; if (zhi_obs !== 32'd0) $display("FAIL mul_zhi: got %0d want 0", zhi_obs); else pass_count++;
        $display("test_mul done");
    endtask

    task automatic test_div();
        set_inport(32'd7);          INPORTout = 1; Yin = 1; tick();
        set_inport(32'h78000000);   INPORTout = 1; IRin = 1; tick();
        set_inport(32'hFFFFFFFD);   INPORTout = 1; Zin = 1; tick();
        clear_ctl();
        check_count++; if (zlo_obs !== 32'hFFFFFFFE) $display("FAIL div_quot: got %h want fffffffe", zlo_obs); else pass_count++;
        check_count++; if (zhi_obs !== 32'd1) $display("FAIL div_rem: got %h want 1", zhi_obs); else pass_count++;
        set_inport(32'd0);          INPORTout = 1; Zin = 1; tick();
        clear_ctl();
        check_count++; if ({zhi_obs, zlo_obs} !== 64'd0) $display("FAIL div_by_zero: got %h want 0", {zhi_obs, zlo_obs}); else pass_count++;
        $display("test_div done");
    endtask

    task automatic test_alu_ops();
        logic [4:0]  ops  [7] = '{5'b00100, 5'b00111, 5'b01000, 5'b01010, 5'b01011, 5'b10001, 5'b00011};
        logic [31:0] bval [7] = '{32'd1, 32'd4, 32'd4, 32'd4, 32'd4, 32'd1, 32'd1};
        logic [31:0] exp_lo [7] = '{32'h80000000, 32'h18000000, 32'h00000018, 32'hF8000000,
                                    32'h00000010, 32'hFFFFFFFF, 32'h80000002};
        set_inport(32'h80000001); INPORTout = 1; Yin = 1; tick();
        for (int i = 0; i < 7; i++) begin
            set_inport({ops[i], 27'd0}); INPORTout = 1; IRin = 1; tick();
            set_inport(bval[i]);         INPORTout = 1; Zin = 1; tick();
            clear_ctl();
            check_count++;
            if ({zhi_obs, zlo_obs} !== {32'd0, exp_lo[i]})
                $display("FAIL alu_op_%b: got %h want %h", ops[i], {zhi_obs, zlo_obs}, {32'd0, exp_lo[i]});
            else pass_count++;
        end
        $display("test_alu_ops done");
    endtask

    task automatic test_baout();
        set_inport(32'd9);        INPORTout = 1; regIn[0] = 1; tick();
        set_inport(32'h78000000); INPORTout = 1; IRin = 1; tick();
        clear_ctl(); Gra = 1; BAout = 1;
        #1;
        check_count++; if (busMuxOut !== 32'd0) $display("FAIL baout_bus: got %0d want 0", busMuxOut); else pass_count++;
        check_count++; if (encoderOut !== 5'd0) $display("FAIL baout_enc: got %0d want 0", encoderOut); else pass_count++;
        clear_ctl(); Gra = 1; Rout = 1;
        #1;
        check_count++; if (busMuxOut !== 32'd9) $display("FAIL rout_r0_bus: got %0d want 9", busMuxOut); else pass_count++;
        clear_ctl();
        $display("test_baout done");
    endtask

    task automatic test_con();
        // IR[20:19]=00: CON set when bus is zero.
        set_inport(32'd9);
        CONin = 1; tick();
        clear_ctl();
        check_count++; if (CON !== 1'b1) $display("FAIL con_eq_zero: got %b want 1", CON); else pass_count++;
        INPORTout = 1; CONin = 1; tick();
        clear_ctl();
        check_count++; if (CON !== 1'b0) $display("FAIL con_eq_nonzero: got %b want 0", CON); else pass_count++;
        $display("test_con done");
    endtask

    task automatic test_back_to_back();
        clear_ctl();
        PCout = 1; PCin = 1; IncPC = 1;
        #1;
        check_count++; if (busMuxOut !== 32'd17) $display("FAIL b2b_bus_old_pc: got %0d want 17", busMuxOut); else pass_count++;
        tick();
        clear_ctl();
        check_count++; if (pc_obs !== 32'd18) $display("FAIL b2b_pc_new: got %0d want 18", pc_obs); else pass_count++;
        $display("test_back_to_back done");
    endtask

    task automatic test_clear_mid_t1();
        set_inport(32'h12345678);
        PCout = 1; MARin = 1; tick();
        clear_ctl();
        Read = 1; MDRin = 1; PCin = 1; IncPC = 1;
        #2;
        Clear = 1'b1;
        #1;
        check_count++; if (pc_obs !== 32'd0) $display("FAIL clr_pc: got %h want 0", pc_obs); else pass_count++;
        check_count++; if (ir_obs !== 32'd0) $display("FAIL clr_ir: got %h want 0", ir_obs); else pass_count++;
        check_count++; if (mar_obs !== 9'd0) $display("FAIL clr_mar: got %h want 0", mar_obs); else pass_count++;
        check_count++; if (y_obs !== 32'd0) $display("FAIL clr_y: got %h want 0", y_obs); else pass_count++;
        check_count++; if (lo_obs !== 32'd0) $display("FAIL clr_lo: got %h want 0", lo_obs); else pass_count++;
        check_count++; if (r_obs[6] !== 32'd0) $display("FAIL clr_r6: got %h want 0", r_obs[6]); else pass_count++;
        check_count++; if (r_obs[0] !== 32'd0) $display("FAIL clr_r0: got %h want 0", r_obs[0]); else pass_count++;
        check_count++; if (inport_obs !== 32'd0) $display("FAIL clr_inport: got %h want 0", inport_obs); else pass_count++;
        check_count++; if (outport_obs !== 32'd0) $display("FAIL clr_outport: got %h want 0", outport_obs); else pass_count++;
        check_count++; if (CON !== 1'b0) $display("FAIL clr_con: got %b want 0", CON); else pass_count++;
        tick();
        check_count++; if (pc_obs !== 32'd0) $display("FAIL clr_hold_pc: got %h want 0", pc_obs); else pass_count++;
        check_count++; if (mdr_obs !== 32'd0) $display("FAIL clr_hold_mdr: got %h want 0", mdr_obs); else pass_count++;
        Clear = 1'b0;
        clear_ctl();
        tick();
        $display("test_clear_mid_t1 done");
    endtask

    initial begin
        test_reset();
        test_inport_to_pc();
        test_lo_load();
        test_fetch();
        test_mul();
        test_div();
        test_alu_ops();
        test_baout();
        test_con();
        test_back_to_back();
        test_clear_mid_t1();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
